// File: rtl/rv32im_pkg.sv
// Shared RV32IM decode constants, M-unit FSM states and op classification helpers.
package rv32im_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ITER = 32;

  // ALU op codes, shared with the single-cycle ALU decoder.
  localparam logic [4:0] OpAnd    = 5'b00000;
  localparam logic [4:0] OpLui    = 5'b00001;
  localparam logic [4:0] OpAdd    = 5'b00010;
  localparam logic [4:0] OpSub    = 5'b00011;
  localparam logic [4:0] OpSll    = 5'b00100;
  localparam logic [4:0] OpSlt    = 5'b00101;
  localparam logic [4:0] OpSltu   = 5'b00110;
  localparam logic [4:0] OpXor    = 5'b00111;
  localparam logic [4:0] OpSrl    = 5'b01000;
  localparam logic [4:0] OpMulu   = 5'b01001;
  localparam logic [4:0] OpMulhs  = 5'b01010;
  localparam logic [4:0] OpMulhsu = 5'b01011;
  localparam logic [4:0] OpMulhu  = 5'b01100;
  localparam logic [4:0] OpDivu   = 5'b01101;
  localparam logic [4:0] OpDivs   = 5'b01110;
  localparam logic [4:0] OpRemu   = 5'b01111;
  localparam logic [4:0] OpRems   = 5'b10000;
  localparam logic [4:0] OpSra    = 5'b10001;
  localparam logic [4:0] OpOr     = 5'b10010;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    FIX,
    FAST,
    DONE
  } muldiv_state_t;

  // True for any op handled by the iterative M unit.
  function automatic logic is_m_op(input logic [4:0] op);
    return (op >= OpMulu) && (op <= OpRems);
  endfunction

  // True for the four multiply flavours.
  function automatic logic is_mul_op(input logic [4:0] op);
    return (op >= OpMulu) && (op <= OpMulhu);
  endfunction

  // True for the two remainder flavours.
  function automatic logic is_rem_op(input logic [4:0] op);
    return (op == OpRemu) || (op == OpRems);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// One iteration of shift-add multiply or restoring divide on a packed 64-bit accumulator.
// Mul: acc = {partial_hi, multiplier_lo}, opnd = multiplicand.
// Div: acc = {remainder, dividend/quotient}, opnd = divisor.
module muldiv_core (
  input  logic        mode_div_i,
  input  logic [63:0] acc_i,
  input  logic [31:0] opnd_i,
  output logic [63:0] acc_o,
  output logic        q_bit_o
);

  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic [31:0] rem_sub;
  logic        q_bit;

  // Single-step datapath; quotient bit is left to the caller to merge into acc_o[0].
  always_comb begin
    sum     = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opnd_i} : 33'd0);
    rem_sh  = acc_i[63:31];
    // A set bit 32 means the shifted remainder already exceeds any 32-bit divisor.
    q_bit   = rem_sh[32] | (rem_sh[31:0] >= opnd_i);
    rem_sub = rem_sh[31:0] - opnd_i;
    if (mode_div_i) begin
      q_bit_o = q_bit;
      acc_o   = {(q_bit ? rem_sub : rem_sh[31:0]), acc_i[30:0], 1'b0};
    end else begin
      q_bit_o = 1'b0;
      acc_o   = {sum, acc_i[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32 M-extension sequencer: captures operands, runs 32 mul/div steps,
// applies sign correction and returns one result with a single-cycle valid pulse.
module muldiv_seq
  import rv32im_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [4:0]      alu_op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o
);

  localparam int unsigned CntW = $clog2(ITER);

  muldiv_state_t   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [63:0]     acc_q, acc_d;
  logic [31:0]     opnd_q, opnd_d;
  logic [31:0]     result_q, result_d;

  logic        accept;
  logic        sgn_a_op, sgn_b_op, sa, sb;
  logic [31:0] abs_a, abs_b;
  logic        new_mul, new_rem, div_zero, div_ovf;
  logic [31:0] fast_val;
  logic [63:0] step_acc;
  logic        step_q;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, fix_val;

  muldiv_core u_core (
    .mode_div_i (!is_mul_op(op_q)),
    .acc_i      (acc_q),
    .opnd_i     (opnd_q),
    .acc_o      (step_acc),
    .q_bit_o    (step_q)
  );

  // Request decode: signs, magnitudes and special-case detection on the incoming operands.
  always_comb begin
    sgn_a_op = (alu_op_i == OpMulhs) || (alu_op_i == OpMulhsu) ||
               (alu_op_i == OpDivs)  || (alu_op_i == OpRems);
    sgn_b_op = (alu_op_i == OpMulhs) || (alu_op_i == OpDivs) || (alu_op_i == OpRems);
    sa       = sgn_a_op & a_i[31];
    sb       = sgn_b_op & b_i[31];
    abs_a    = sa ? (32'd0 - a_i) : a_i;
    abs_b    = sb ? (32'd0 - b_i) : b_i;
    new_mul  = is_mul_op(alu_op_i);
    new_rem  = is_rem_op(alu_op_i);
    div_zero = !new_mul && (b_i == 32'd0);
    div_ovf  = ((alu_op_i == OpDivs) || (alu_op_i == OpRems)) &&
               (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
    if (div_zero) begin
      fast_val = new_rem ? a_i : 32'hFFFF_FFFF;
    end else begin
      fast_val = new_rem ? 32'd0 : 32'h8000_0000;
    end
    accept   = valid_i && (state_q == IDLE) && is_m_op(alu_op_i) && !flush_i;
  end

  // Sign correction and result selection for the FIX state.
  always_comb begin
    prod_fix = neg_q ? (64'd0 - acc_q) : acc_q;
    quo_fix  = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    rem_fix  = neg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    case (op_q)
      OpMulu:                     fix_val = prod_fix[31:0];
      OpMulhs, OpMulhsu, OpMulhu: fix_val = prod_fix[63:32];
      OpDivu, OpDivs:             fix_val = quo_fix;
      default:                    fix_val = rem_fix;
    endcase
  end

  // FSM next state plus datapath register updates; flush overrides everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = alu_op_i;
          neg_d = new_rem ? sa : (sa ^ sb);
          cnt_d = '0;
          if (div_zero || div_ovf) begin
            state_d = FAST;
            acc_d   = {32'd0, fast_val};
          end else begin
            state_d = CALC;
            acc_d   = {32'd0, (new_mul ? abs_b : abs_a)};
            opnd_d  = new_mul ? abs_a : abs_b;
          end
        end
      end
      CALC: begin
        acc_d = step_acc | {63'd0, step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(ITER - 1)) begin
          state_d = FIX;
          cnt_d   = '0;
        end
      end
      FIX: begin
        result_d = fix_val;
        state_d  = DONE;
      end
      FAST: begin
        result_d = acc_q[31:0];
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (flush_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      opnd_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
    end
  end

  // Handshake outputs; the valid pulse is masked by a same-cycle flush.
  always_comb begin
    ready_o        = (state_q == IDLE);
    busy_o         = (state_q != IDLE);
    result_o       = result_q;
    result_valid_o = (state_q == DONE) && !flush_i;
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with hand-computed expected results and latencies.
module tb_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [4:0]  alu_op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic        ready_o;
  logic        busy_o;
  logic [31:0] result_o;
  logic        result_valid_o;

  int n_vec  = 0;
  int n_miss = 0;

  muldiv_seq u_dut (
    .clk            (clk),
    .rst            (rst),
    .valid_i        (valid_i),
    .alu_op_i       (alu_op_i),
    .a_i            (a_i),
    .b_i            (b_i),
    .flush_i        (flush_i),
    .ready_o        (ready_o),
    .busy_o         (busy_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble operands after acceptance, wait for the pulse and check it.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int   lat;
    logic busy_ok;
    chk({tag, "/ready"}, 64'(ready_o), 64'd1);
    valid_i  = 1'b1;
    alu_op_i = op;
    a_i      = a;
    b_i      = b;
    @(posedge clk); #1;
    valid_i  = 1'b0;
    a_i      = $urandom;
    b_i      = $urandom;
    lat      = 0;
    busy_ok  = 1'b1;
    while (!result_valid_o && lat < 60) begin
      busy_ok = busy_ok & busy_o & !ready_o;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "/result"}, 64'(result_o), 64'(exp));
    chk({tag, "/busy"}, 64'(busy_ok), 64'd1);
    @(posedge clk); #1;
    chk({tag, "/one_pulse"}, 64'({result_valid_o, ready_o}), 64'b01);
  endtask

  initial begin
    logic seen;
    rst      = 1'b1;
    valid_i  = 1'b0;
    alu_op_i = 5'd0;
    a_i      = '0;
    b_i      = '0;
    flush_i  = 1'b0;
    #2;
    chk("reset_outputs", 64'({ready_o, busy_o, result_valid_o}), 64'b100);
    chk("reset_result", 64'(result_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Multiplies: 33 edges from acceptance to the DONE cycle.
    run_op("mulu_7x6",      5'b01001, 32'd7,        32'd6,        32'h0000_002A, 33);
    run_op("mulhs_m2x3",    5'b01010, 32'hFFFF_FFFE, 32'd3,       32'hFFFF_FFFF, 33);
    run_op("mulhu_max",     5'b01100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulhsu_m1x2",   5'b01011, 32'hFFFF_FFFF, 32'd2,       32'hFFFF_FFFF, 33);

    // Divides.
    run_op("divs_m7_2",     5'b01110, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD, 33);
    run_op("rems_m7_2",     5'b10000, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, 33);
    run_op("divu_100_7",    5'b01101, 32'd100,      32'd7,        32'd14,        33);
    run_op("remu_100_7",    5'b01111, 32'd100,      32'd7,        32'd2,         33);

    // Flush mid-divide: no pulse, result keeps 2, unit idle next cycle.
    valid_i  = 1'b1;
    alu_op_i = 5'b01110;
    a_i      = 32'hFFFF_FFF9;
    b_i      = 32'd2;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush_i = 1'b1;
    #1;
    chk("flush_busy_before", 64'(busy_o), 64'd1);
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_ready", 64'({ready_o, busy_o}), 64'b10);
    chk("flush_result_held", 64'(result_o), 64'd2);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen = seen | result_valid_o;
    end
    chk("flush_no_pulse", 64'(seen), 64'd0);
    run_op("mulu_3x3", 5'b01001, 32'd3, 32'd3, 32'd9, 33);

    // Flush together with a request in IDLE: nothing accepted.
    valid_i  = 1'b1;
    flush_i  = 1'b1;
    alu_op_i = 5'b01001;
    a_i      = 32'd5;
    b_i      = 32'd5;
    @(posedge clk); #1;
    valid_i = 1'b0;
    flush_i = 1'b0;
    chk("flush_vs_valid", 64'({ready_o, busy_o}), 64'b10);

    // Special cases take the FAST path: DONE one edge after acceptance.
    run_op("divu_by0",      5'b01101, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
    run_op("remu_by0",      5'b01111, 32'd5,        32'd0,        32'd5,         1);
    run_op("divs_ovf",      5'b01110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rems_ovf",      5'b10000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1);

    // Reset asserted between edges in the middle of a divide.
    valid_i  = 1'b1;
    alu_op_i = 5'b01101;
    a_i      = 32'd1000;
    b_i      = 32'd3;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", 64'({ready_o, busy_o, result_valid_o}), 64'b100);
    chk("async_rst_result", 64'(result_o), 64'd0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;

    // Non-M op is never accepted.
    valid_i  = 1'b1;
    alu_op_i = 5'b00010;
    a_i      = 32'd1;
    b_i      = 32'd2;
    seen     = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen = seen | busy_o | !ready_o | result_valid_o;
    end
    valid_i = 1'b0;
    chk("non_m_ignored", 64'(seen), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
